pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generation stage; sits directly upstream of the fetch stage and drives its pc input.
- Holds the architectural PC, advances it by 4 each cycle, and applies branch/jump redirects from execute.
- Supports stall, halt/resume (ebreak) and misaligned-target trap.
- Single-cycle RV32I core; PC is always 32 bits.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned redirect target is detected.

Ports:
- clk  input  1  clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- stall_i  input  1  hold PC this cycle
- branch_taken_i  input  1  conditional branch taken
- branch_target_i  input  32  branch target address
- jump_i  input  1  JAL/JALR redirect
- jump_target_i  input  32  jump target; bit0 forced to 0 internally
- halt_i  input  1  enter HALT (ebreak)
- resume_i  input  1  leave HALT
- pc_o  output  32  current PC, to fetch
- pc_plus4_o  output  32  pc_o + 4 (mod 2^32), combinational
- pc_valid_o  output  1  pc_o is a valid fetch address
- misalign_o  output  1  high for the TRAP cycle
- trap_addr_o  output  32  last offending target
- state_o  output  2  BOOT=00, RUN=01, HALT=10, TRAP=11
- redirect_cnt_o  output  32  redirect count (optional feature)

Behaviour:
- Reset (async assert): pc_o=RESET_VECTOR, state=BOOT, trap_addr_o=0, redirect_cnt_o=0. Combinational outputs under reset: pc_valid_o=0, misalign_o=0, pc_plus4_o=RESET_VECTOR+4.
- Reset asserted mid-operation forces these values immediately, regardless of state.
- pc_valid_o = (state==RUN); misalign_o = (state==TRAP). Both are combinational from state.
- BOOT:
  - First rising edge after reset release -> RUN; pc unchanged.
  - All inputs ignored.
  - pc_valid therefore rises one cycle after reset release, matching fetch request timing.
- RUN: at each rising edge, the first matching rule applies:
  1. halt_i -> HALT; pc held.
  2. stall_i -> pc held; state RUN.
  3. jump_i -> target T = {jump_target_i[31:1],1'b0}.
     - If T[1] != 0: TRAP, pc <= TRAP_VECTOR, trap_addr_o <= T.
     - Else pc <= T.
  4. branch_taken_i -> T = branch_target_i.
     - If T[1:0] != 0: TRAP, pc <= TRAP_VECTOR, trap_addr_o <= T.
     - Else pc <= T.
  5. Otherwise pc <= pc + 4; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Priority notes:
  - jump_i and branch_taken_i together: jump wins.
  - stall_i suppresses a same-cycle redirect; upstream must hold the redirect until the stall drops.
  - halt_i and stall_i together: HALT.
  - resume_i is ignored in RUN.
- HALT:
  - pc held.
  - resume_i -> RUN; pc unchanged, so fetch restarts at the held PC.
  - halt_i, stall_i and redirects are ignored.
- TRAP:
  - Lasts exactly one cycle; pc_o=TRAP_VECTOR.
  - Next edge -> RUN unconditionally; stall/halt/redirects ignored.
  - trap_addr_o holds its value until the next trap.
- Latency: every redirect is visible on pc_o one cycle after the edge that samples it.

Optional Feature:
- Macro: PCGEN_PERF_EN.
- Defined:
  - redirect_cnt_o increments by 1 on every edge where RUN accepts a jump or taken branch (rules 3/4), including trapping ones.
  - Wraps modulo 2^32; reset to 0.
- Undefined: redirect_cnt_o tied to 32'h0; no counter flops.

Test Plan:
- Reset release, no inputs:
  - 1 cycle BOOT with pc_o=0, pc_valid_o=0.
  - Then pc_o=0,4,8,12 on successive cycles with pc_valid_o=1.
- At pc=0x10:
  - jump_i with jump_target_i=0x41 -> next pc_o=0x40.
  - Same cycle with branch_taken_i, target 0x80 -> still 0x40 (jump wins).
- branch_taken_i, target 0x0000_0202:
  - Next cycle state=TRAP, misalign_o=1, pc_o=0x100, trap_addr_o=0x202.
  - Following cycle RUN at 0x100, then 0x104.
- stall_i held 3 cycles at pc=0x20 with a branch to 0x60 during the stall -> pc_o stays 0x20, then 0x24 after release.
- halt_i at pc=0x30:
  - HALT, pc_valid_o=0, pc 0x30 held for 5 cycles.
  - resume_i -> RUN with pc_o=0x30, then 0x34.
- Wrap and counter:
  - Force pc to 0xFFFF_FFFC via jump -> next pc_o=0x0.
  - With PCGEN_PERF_EN, 3 redirects -> redirect_cnt_o=3.
  - Without PCGEN_PERF_EN -> redirect_cnt_o=0.
  - reset_n asserted mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generation stage for a single-cycle RV32I
//               core. Holds the architectural PC, advances it by 4 per cycle,
//               applies jump/branch redirects, and supports stall, halt/resume
//               and a one-cycle misaligned-target trap.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   RESET_VECTOR    PC loaded on reset
//   TRAP_VECTOR     PC loaded on a misaligned redirect target
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   stall_i         hold PC this cycle
//   branch_taken_i  conditional branch taken, target on branch_target_i
//   jump_i          JAL/JALR redirect, target on jump_target_i (bit0 dropped)
//   halt_i          enter HALT (ebreak)
//   resume_i        leave HALT
//   pc_o            current PC to fetch
//   pc_plus4_o      pc_o + 4, combinational
//   pc_valid_o      high while in RUN
//   misalign_o      high for the single TRAP cycle
//   trap_addr_o     last offending redirect target
//   state_o         BOOT=00, RUN=01, HALT=10, TRAP=11
//   redirect_cnt_o  accepted redirect count
// Configuration:
//   PCGEN_PERF_EN   when defined, redirect_cnt_o counts accepted redirects;
//                   otherwise it is tied to zero and no counter exists.
// ============================================================================
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pc_valid_o,
  output logic        misalign_o,
  output logic [31:0] trap_addr_o,
  output logic [1:0]  state_o,
  output logic [31:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_TRAP = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_trap_addr;

  logic [31:0] w_jump_target;
  logic        w_redirect_accept;
  logic [31:0] w_pc_plus4;

  // JALR can produce an odd target; bit0 is architecturally discarded.
  assign w_jump_target = jump_target_i & ~32'h0000_0001;
  assign w_pc_plus4    = r_pc + 32'd4;

  // A redirect is only taken in RUN when neither halt nor stall wins first.
  assign w_redirect_accept = (r_state == ST_RUN) && !halt_i && !stall_i &&
                             (jump_i || branch_taken_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_trap_addr <= 32'h0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (halt_i) begin
            r_state <= ST_HALT;
          end else if (stall_i) begin
            r_state <= ST_RUN;
          end else if (jump_i) begin
            if (w_jump_target[1]) begin
              r_state     <= ST_TRAP;
              r_pc        <= TRAP_VECTOR;
              r_trap_addr <= w_jump_target;
            end else begin
              r_pc <= w_jump_target;
            end
          end else if (branch_taken_i) begin
            if (branch_target_i[1:0] != 2'b00) begin
              r_state     <= ST_TRAP;
              r_pc        <= TRAP_VECTOR;
              r_trap_addr <= branch_target_i;
            end else begin
              r_pc <= branch_target_i;
            end
          end else begin
            r_pc <= w_pc_plus4;
          end
        end
        ST_HALT: begin
          if (resume_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_TRAP: r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

`ifdef PCGEN_PERF_EN
  logic [31:0] r_redirect_cnt;

  // Trapping redirects count too: the redirect was accepted, only its target
  // was bad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redirect_cnt <= 32'h0;
    end else if (w_redirect_accept) begin
      r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign redirect_cnt_o = r_redirect_cnt;
`else
  assign redirect_cnt_o = 32'h0;
`endif

  assign pc_o        = r_pc;
  assign pc_plus4_o  = w_pc_plus4;
  assign pc_valid_o  = (r_state == ST_RUN);
  assign misalign_o  = (r_state == ST_TRAP);
  assign trap_addr_o = r_trap_addr;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen. Walks through boot,
//               sequential fetch, jump/branch priority, misaligned trap,
//               stall, halt/resume, wrap, redirect counting and async reset.
// Revision    : 1.0 - initial release
// Configuration:
//   PCGEN_PERF_EN   expected redirect counts follow the same macro as the DUT
// ============================================================================
module tb_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        halt_i;
  logic        resume_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic        misalign_o;
  logic [31:0] trap_addr_o;
  logic [1:0]  state_o;
  logic [31:0] redirect_cnt_o;

  int n_cmp;
  int n_err;

`ifdef PCGEN_PERF_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  pc_gen #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .pc_valid_o     (pc_valid_o),
    .misalign_o     (misalign_o),
    .trap_addr_o    (trap_addr_o),
    .state_o        (state_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    jump_i          = 1'b0;
    jump_target_i   = 32'h0;
    halt_i          = 1'b0;
    resume_i        = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},     pc_o,                  32'h0);
    check({tag, "_pc4"},    pc_plus4_o,            32'h4);
    check({tag, "_valid"},  {31'h0, pc_valid_o},   32'h0);
    check({tag, "_mis"},    {31'h0, misalign_o},   32'h0);
    check({tag, "_taddr"},  trap_addr_o,           32'h0);
    check({tag, "_state"},  {30'h0, state_o},      32'h0);
    check({tag, "_cnt"},    redirect_cnt_o,        32'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    clear_inputs();

    // Reset held across a couple of edges.
    #22;
    check_reset_values("rst");

    // Release between edges; BOOT visible until the next edge.
    reset_n = 1'b1;
    #1;
    check("boot_state", {30'h0, state_o}, 32'h0);
    check("boot_valid", {31'h0, pc_valid_o}, 32'h0);
    check("boot_pc", pc_o, 32'h0);

    // Drive junk during BOOT; it must be ignored.
    jump_i = 1'b1; jump_target_i = 32'h0000_0800; halt_i = 1'b1;
    step();
    clear_inputs();
    check("run_state", {30'h0, state_o}, 32'h1);
    check("run_valid", {31'h0, pc_valid_o}, 32'h1);
    check("seq_pc0", pc_o, 32'h0);
    step(); check("seq_pc4", pc_o, 32'h4);
    step(); check("seq_pc8", pc_o, 32'h8);
    step(); check("seq_pc12", pc_o, 32'hC);
    check("seq_pc4o", pc_plus4_o, 32'h10);
    check("cnt_boot", redirect_cnt_o, 32'h0);
    step(); check("seq_pc16", pc_o, 32'h10);

    // Jump and branch together: jump wins, bit0 of jump target dropped.
    jump_i = 1'b1; jump_target_i = 32'h0000_0041;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0080;
    step();
    clear_inputs();
    check("jmp_pc", pc_o, 32'h40);
    check("jmp_cnt", redirect_cnt_o, c_perf ? 32'd1 : 32'd0);

    // Misaligned branch target traps.
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0202;
    step();
    clear_inputs();
    check("trap_state", {30'h0, state_o}, 32'h3);
    check("trap_mis", {31'h0, misalign_o}, 32'h1);
    check("trap_valid", {31'h0, pc_valid_o}, 32'h0);
    check("trap_pc", pc_o, 32'h100);
    check("trap_addr", trap_addr_o, 32'h202);
    // Redirect in TRAP must be ignored.
    jump_i = 1'b1; jump_target_i = 32'h0000_0500;
    step();
    clear_inputs();
    check("post_trap_state", {30'h0, state_o}, 32'h1);
    check("post_trap_pc", pc_o, 32'h100);
    check("post_trap_mis", {31'h0, misalign_o}, 32'h0);
    step(); check("post_trap_pc2", pc_o, 32'h104);
    check("trap_addr_hold", trap_addr_o, 32'h202);

    // Jump to 0x20, then stall three cycles with a pending branch.
    jump_i = 1'b1; jump_target_i = 32'h0000_0020;
    step();
    clear_inputs();
    check("jmp20_pc", pc_o, 32'h20);
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h0000_0060;
    step(); check("stall_pc1", pc_o, 32'h20);
    step(); check("stall_pc2", pc_o, 32'h20);
    step(); check("stall_pc3", pc_o, 32'h20);
    check("stall_valid", {31'h0, pc_valid_o}, 32'h1);
    clear_inputs();
    step(); check("unstall_pc", pc_o, 32'h24);
    check("cnt3", redirect_cnt_o, c_perf ? 32'd3 : 32'd0);

    // Halt at 0x30 with stall also asserted: HALT wins.
    jump_i = 1'b1; jump_target_i = 32'h0000_0030;
    step();
    clear_inputs();
    check("jmp30_pc", pc_o, 32'h30);
    halt_i = 1'b1; stall_i = 1'b1;
    step();
    clear_inputs();
    check("halt_state", {30'h0, state_o}, 32'h2);
    check("halt_valid", {31'h0, pc_valid_o}, 32'h0);
    check("halt_pc1", pc_o, 32'h30);
    // Redirects and stall ignored during HALT.
    jump_i = 1'b1; jump_target_i = 32'h0000_0400;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0203;
    step(); check("halt_pc2", pc_o, 32'h30);
    step(); check("halt_pc3", pc_o, 32'h30);
    step(); check("halt_pc4", pc_o, 32'h30);
    step(); check("halt_pc5", pc_o, 32'h30);
    check("halt_state5", {30'h0, state_o}, 32'h2);
    clear_inputs();
    resume_i = 1'b1;
    step();
    clear_inputs();
    check("resume_state", {30'h0, state_o}, 32'h1);
    check("resume_pc", pc_o, 32'h30);
    step(); check("resume_pc2", pc_o, 32'h34);
    check("cnt4", redirect_cnt_o, c_perf ? 32'd4 : 32'd0);

    // Wrap at top of address space.
    jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    check("top_pc", pc_o, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus4_o, 32'h0);
    step(); check("wrap_pc", pc_o, 32'h0);

    // Misaligned jump: 0x47 -> 0x46 after bit0 drop, bit1 set -> trap.
    jump_i = 1'b1; jump_target_i = 32'h0000_0047;
    step();
    clear_inputs();
    check("jtrap_state", {30'h0, state_o}, 32'h3);
    check("jtrap_pc", pc_o, 32'h100);
    check("jtrap_addr", trap_addr_o, 32'h46);
    check("cnt6", redirect_cnt_o, c_perf ? 32'd6 : 32'd0);
    step();
    check("jtrap_run", pc_o, 32'h100);
    step();
    check("jtrap_run2", pc_o, 32'h104);

    // Asynchronous reset mid-RUN, asserted away from any edge.
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    #20;
    reset_n = 1'b1;
    step();
    check("rerun_pc", pc_o, 32'h0);
    check("rerun_state", {30'h0, state_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
